// File: rtl/dcache_ctrl.sv
// Lookup/miss controller for a direct-mapped write-back data cache with 16-byte lines.
// Handles hit check, store merge, dirty writeback and two-beat refill over a 64-bit memory port.
module dcache_ctrl #(
    parameter int SETS  = 128,
    parameter int BEATS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic [63:0]   cpu_req_addr,
    input  logic          cpu_req_wen,
    input  logic [63:0]   cpu_req_wdata,
    input  logic [7:0]    cpu_req_wmask,
    output logic          cpu_resp_valid,
    output logic [63:0]   cpu_resp_rdata,
    output logic [6:0]    tag_addr,
    output logic          tag_en,
    output logic [54:0]   tag_wdata,
    input  logic [54:0]   tag_rdata,
    output logic [6:0]    data_addr,
    output logic          data_en,
    output logic [127:0]  data_wdata,
    input  logic [127:0]  data_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_wen,
    output logic [63:0]   mem_req_addr,
    output logic [63:0]   mem_req_wdata,
    input  logic          mem_resp_valid,
    input  logic [63:0]   mem_resp_rdata
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 64 - 4 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_RF_REQ, S_RF_WAIT, S_RESP
    } state_t;

    state_t             r_state, w_next;
    logic [63:0]        r_addr, r_wdata, r_rword;
    logic               r_wen, r_beat;
    logic [7:0]         r_wmask;
    logic [127:0]       r_line;
    logic [TAG_W-1:0]   r_old_tag;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit, w_victim_dirty, w_last_beat, w_unused;
    logic [63:0]        w_old_word, w_merged, w_line_word;
    logic [127:0]       w_store_line;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                                input logic [63:0] new_w,
                                                input logic [7:0]  mask);
        logic [63:0] res;
        res = old_w;
        for (int b = 0; b < 8; b++)
            if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    assign w_idx          = r_addr[IDX_W+3:4];
    assign w_tag          = r_addr[63:IDX_W+4];
    assign w_hit          = tag_rdata[54] && (tag_rdata[TAG_W-1:0] == w_tag);
    assign w_victim_dirty = tag_rdata[54] && tag_rdata[53];
    assign w_last_beat    = (r_beat == 1'(BEATS-1));
    assign w_old_word     = r_addr[3] ? data_rdata[127:64] : data_rdata[63:0];
    assign w_merged       = merge_bytes(w_old_word, r_wdata, r_wmask);
    assign w_store_line   = r_addr[3] ? {w_merged, data_rdata[63:0]}
                                      : {data_rdata[127:64], w_merged};
    assign w_line_word    = r_beat ? r_line[127:64] : r_line[63:0];
    assign w_unused       = ^r_addr[2:0];
    assign tag_addr       = w_idx;
    assign data_addr      = w_idx;

    always_comb begin
        w_next         = r_state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        tag_en         = 1'b0;
        tag_wdata      = '0;
        data_en        = 1'b0;
        data_wdata     = '0;
        mem_req_valid  = 1'b0;
        mem_req_wen    = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    if (r_wen) begin
                        data_en    = 1'b1;
                        data_wdata = w_store_line;
                        tag_en     = 1'b1;
                        tag_wdata  = {1'b1, 1'b1, w_tag};
                    end
                    w_next = S_RESP;
                end else if (w_victim_dirty) begin
                    w_next = S_WB_REQ;
                end else begin
                    w_next = S_RF_REQ;
                end
            end
            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = 1'b1;
                mem_req_addr  = {r_old_tag, w_idx, r_beat, 3'b000};
                mem_req_wdata = w_line_word;
                if (mem_req_ready) w_next = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (mem_resp_valid) w_next = w_last_beat ? S_RF_REQ : S_WB_REQ;
            end
            S_RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_tag, w_idx, r_beat, 3'b000};
                if (mem_req_ready) w_next = S_RF_WAIT;
            end
            S_RF_WAIT: begin
                if (mem_resp_valid) begin
                    if (w_last_beat) begin
                        // Install the line, then replay the lookup, which now hits.
                        data_en    = 1'b1;
                        data_wdata = {mem_resp_rdata, r_line[63:0]};
                        tag_en     = 1'b1;
                        tag_wdata  = {1'b1, 1'b0, w_tag};
                        w_next     = S_LOOKUP;
                    end else begin
                        w_next = S_RF_REQ;
                    end
                end
            end
            S_RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = r_wen ? 64'd0 : r_rword;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset silences every strobe so the arrays and memory see nothing mid-reset.
        if (rst) begin
            cpu_req_ready  = 1'b0;
            cpu_resp_valid = 1'b0;
            cpu_resp_rdata = '0;
            tag_en         = 1'b0;
            data_en        = 1'b0;
            mem_req_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOOKUP:  r_beat <= 1'b0;
                S_WB_WAIT: if (mem_resp_valid) r_beat <= ~r_beat;
                S_RF_WAIT: if (mem_resp_valid) r_beat <= ~r_beat;
                default:   r_beat <= r_beat;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cpu_req_valid) begin
            r_addr  <= cpu_req_addr;
            r_wen   <= cpu_req_wen;
            r_wdata <= cpu_req_wdata;
            r_wmask <= cpu_req_wmask;
        end
        if (r_state == S_LOOKUP) begin
            if (w_hit && !r_wen) r_rword <= w_old_word;
            if (!w_hit && w_victim_dirty) begin
                r_line    <= data_rdata;
                r_old_tag <= tag_rdata[TAG_W-1:0];
            end
        end
        if (r_state == S_RF_WAIT && mem_resp_valid) begin
            if (r_beat) r_line[127:64] <= mem_resp_rdata;
            else        r_line[63:0]   <= mem_resp_rdata;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: tag/data arrays, a stalling memory, and a directory-level cache model.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_wen = 1'b0;
    logic [63:0]   cpu_req_addr = '0, cpu_req_wdata = '0;
    logic [7:0]    cpu_req_wmask = '0;
    logic          cpu_resp_valid;
    logic [63:0]   cpu_resp_rdata;
    logic [6:0]    tag_addr, data_addr;
    logic          tag_en, data_en;
    logic [54:0]   tag_wdata, tag_rdata;
    logic [127:0]  data_wdata, data_rdata;
    logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [63:0]   mem_req_addr, mem_req_wdata, mem_resp_rdata;

    dcache_ctrl #(.SETS(128), .BEATS(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wen(cpu_req_wen),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wmask(cpu_req_wmask),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .tag_addr(tag_addr), .tag_en(tag_en), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
        .data_addr(data_addr), .data_en(data_en), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    // Tag and data arrays: combinational read, write at the clock edge.
    logic [54:0]  tag_mem  [128];
    logic [127:0] data_mem [128];
    logic         arr_clr = 1'b1;
    assign tag_rdata  = tag_mem[tag_addr];
    assign data_rdata = data_mem[data_addr];
    always @(posedge clk) begin
        if (arr_clr) begin
            for (int i = 0; i < 128; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (tag_en)  tag_mem[tag_addr]   <= tag_wdata;
            if (data_en) data_mem[data_addr] <= data_wdata;
        end
    end

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0], ~a[31:0]};
    endfunction

    logic [63:0] bmem [logic [60:0]];
    logic [63:0] arch [logic [60:0]];
    function automatic logic [63:0] bmem_rd(input logic [63:0] a);
        return bmem.exists(a[63:3]) ? bmem[a[63:3]] : init_word({a[63:3], 3'b000});
    endfunction
    function automatic logic [63:0] arch_rd(input logic [63:0] a);
        return arch.exists(a[63:3]) ? arch[a[63:3]] : init_word({a[63:3], 3'b000});
    endfunction

    // Reference model: directory of what each set holds, plus architectural memory.
    logic        m_valid [128];
    logic        m_dirty [128];
    logic [52:0] m_tag   [128];

    typedef struct packed { logic wen; logic [63:0] addr; logic [63:0] wdata; } mreq_t;
    typedef struct packed { logic hit; logic [63:0] data; } resp_t;
    mreq_t        q_mem  [$];
    logic [61:0]  q_tag  [$];
    logic [134:0] q_data [$];
    resp_t        q_resp [$];

    task automatic model_issue(input logic [63:0] a, input logic w,
                               input logic [63:0] wd, input logic [7:0] wm);
        logic [6:0]   idx;
        logic [52:0]  tg;
        logic [63:0]  base, word;
        logic         hit;
        mreq_t        m;
        resp_t        r;
        idx  = a[10:4];
        tg   = a[63:11];
        base = {a[63:4], 4'h0};
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int b = 0; b < 2; b++) begin
                    m.wen = 1'b1;
                    m.addr = {m_tag[idx], idx, b[0], 3'b000};
                    m.wdata = arch_rd(m.addr);
                    q_mem.push_back(m);
                end
            end
            for (int b = 0; b < 2; b++) begin
                m.wen = 1'b0;
                m.addr = {tg, idx, b[0], 3'b000};
                m.wdata = '0;
                q_mem.push_back(m);
            end
            q_tag.push_back({idx, 1'b1, 1'b0, tg});
            q_data.push_back({idx, arch_rd(base + 64'd8), arch_rd(base)});
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        r.hit = hit;
        if (w) begin
            word = arch_rd(a);
            for (int b = 0; b < 8; b++)
                if (wm[b]) word[8*b +: 8] = wd[8*b +: 8];
            arch[a[63:3]] = word;
            q_tag.push_back({idx, 1'b1, 1'b1, tg});
            q_data.push_back({idx, arch_rd(base + 64'd8), arch_rd(base)});
            m_dirty[idx] = 1'b1;
            r.data = '0;
        end else begin
            r.data = arch_rd(a);
        end
        q_resp.push_back(r);
    endtask

    // Memory responder: configurable ready stall and response delay.
    logic rand_mode = 1'b0;
    int   cfg_stall = 0, cfg_dly = 0, stray_req = 0;

    initial begin : responder
        logic        s_rst, s_hs, busy, counting, l_wen;
        logic [63:0] l_addr, l_wd;
        int          dly, scnt, starget, stray_done;
        busy = 1'b0; counting = 1'b0; stray_done = 0; dly = 0; scnt = 0; starget = 0;
        l_wen = 1'b0; l_addr = '0; l_wd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_hs  = mem_req_valid && mem_req_ready;
            if (s_hs) begin
                l_addr = mem_req_addr; l_wen = mem_req_wen; l_wd = mem_req_wdata;
            end
            @(posedge clk);
            #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (s_rst) begin
                busy = 1'b0; counting = 1'b0;
                continue;
            end
            if (s_hs) begin
                busy = 1'b1;
                dly  = rand_mode ? int'($urandom_range(0, 3)) : cfg_dly;
            end
            if (busy) begin
                if (dly == 0) begin
                    mem_resp_valid = 1'b1;
                    if (l_wen) begin
                        bmem[l_addr[63:3]] = l_wd;
                        mem_resp_rdata = {$urandom, $urandom};
                    end else begin
                        mem_resp_rdata = bmem_rd(l_addr);
                    end
                    busy = 1'b0;
                end else begin
                    dly--;
                end
            end else if (stray_done != stray_req) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = {$urandom, $urandom};
                stray_done = stray_req;
            end else if (mem_req_valid) begin
                if (!counting) begin
                    counting = 1'b1;
                    scnt     = 0;
                    starget  = rand_mode ? int'($urandom_range(0, 3)) : cfg_stall;
                end
                if (scnt >= starget) begin
                    mem_req_ready = 1'b1;
                    counting = 1'b0;
                end else begin
                    scnt++;
                end
            end
        end
    end

    // Compare process: every DUT event is checked against the model's expectation queues.
    int          cyc = 0, max_stall = 0;
    logic [54:0] last_tag = '0;

    initial begin : cmp
        logic         outstanding, pv;
        int           acc_cyc, stall_run;
        mreq_t        pm, em;
        resp_t        er;
        logic [61:0]  et;
        logic [134:0] ed;
        outstanding = 1'b0; pv = 1'b0; acc_cyc = 0; stall_run = 0; pm = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_req_ready", cpu_req_ready, 1'b0);
                check("rst_strobes", {tag_en, data_en, mem_req_valid, cpu_resp_valid}, 4'b0);
                check("rst_resp_rdata", cpu_resp_rdata, 64'd0);
                q_mem.delete(); q_tag.delete(); q_data.delete(); q_resp.delete();
                outstanding = 1'b0; pv = 1'b0; stall_run = 0;
            end else begin
                check("req_ready", cpu_req_ready, !outstanding);
                if (cpu_req_valid && cpu_req_ready) begin
                    outstanding = 1'b1;
                    acc_cyc = cyc;
                end
                if (tag_en) begin
                    last_tag = tag_wdata;
                    if (q_tag.size() == 0) check("tag_unexpected", tag_en, 1'b0);
                    else begin
                        et = q_tag.pop_front();
                        check("tag_addr", tag_addr, et[61:55]);
                        check("tag_wdata", tag_wdata, et[54:0]);
                    end
                end
                if (data_en) begin
                    if (q_data.size() == 0) check("data_unexpected", data_en, 1'b0);
                    else begin
                        ed = q_data.pop_front();
                        check("data_addr", data_addr, ed[134:128]);
                        check("data_wdata", data_wdata, ed[127:0]);
                    end
                end
                if (mem_req_valid) begin
                    if (pv) begin
                        check("mreq_stable_addr", mem_req_addr, pm.addr);
                        check("mreq_stable_wen", mem_req_wen, pm.wen);
                        check("mreq_stable_wdata", mem_req_wdata, pm.wdata);
                    end
                    if (mem_req_ready) begin
                        stall_run = 0;
                        if (q_mem.size() == 0) check("mreq_unexpected", mem_req_valid, 1'b0);
                        else begin
                            em = q_mem.pop_front();
                            check("mreq_wen", mem_req_wen, em.wen);
                            check("mreq_addr", mem_req_addr, em.addr);
                            if (em.wen) check("mreq_wdata", mem_req_wdata, em.wdata);
                        end
                    end else begin
                        stall_run++;
                        if (stall_run > max_stall) max_stall = stall_run;
                    end
                    pv = !mem_req_ready;
                    pm.addr = mem_req_addr; pm.wen = mem_req_wen; pm.wdata = mem_req_wdata;
                end else begin
                    pv = 1'b0;
                    stall_run = 0;
                end
                if (cpu_resp_valid) begin
                    if (q_resp.size() == 0) check("resp_unexpected", cpu_resp_valid, 1'b0);
                    else begin
                        er = q_resp.pop_front();
                        check("resp_rdata", cpu_resp_rdata, er.data);
                        if (er.hit) check("hit_latency", cyc - acc_cyc, 2);
                    end
                    outstanding = 1'b0;
                end
            end
        end
    end

    task automatic present(input logic [63:0] a, input logic w,
                           input logic [63:0] wd, input logic [7:0] wm);
        int   n;
        logic got;
        @(posedge clk); #1;
        cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_wen = w;
        cpu_req_wdata = wd; cpu_req_wmask = wm;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (cpu_req_ready) got = 1'b1;
            n++;
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = {$urandom, $urandom};
        if (!got) check("accept_timeout", got, 1'b1);
    endtask

    task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] wd,
                          input logic [7:0] wm, output logic [63:0] rd, output int lat);
        int   n;
        logic got;
        model_issue(a, w, wd, wm);
        present(a, w, wd, wm);
        n = 0; got = 1'b0; rd = '0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (cpu_resp_valid) begin
                got = 1'b1;
                rd  = cpu_resp_rdata;
            end
        end
        lat = n;
        if (!got) check("resp_timeout", got, 1'b1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [63:0] rd, a;
        int          lat, ev, n;
        logic        got;
        logic        sv_valid [128];
        logic        sv_dirty [128];
        logic [52:0] sv_tag   [128];
        logic [52:0] tags [3];
        logic [6:0]  idx;

        for (int i = 0; i < 128; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; arr_clr = 1'b0;

        do_req(64'h8000_0010, 1'b0, '0, '0, rd, lat);
        check("cold_load_data", rd, 64'h8000_0010_7FFF_FFEF);
        check("cold_load_tag", last_tag, {1'b1, 1'b0, 53'h100000});

        do_req(64'h8000_0018, 1'b0, '0, '0, rd, lat);
        check("hit_load_data", rd, 64'h8000_0018_7FFF_FFE7);
        check("hit_load_latency", lat, 2);

        do_req(64'h8000_0010, 1'b1, 64'h0000_0000_0000_AABB, 8'h03, rd, lat);
        check("store_hit_rdata", rd, 64'd0);
        check("store_hit_latency", lat, 2);
        check("store_hit_tag", last_tag, {1'b1, 1'b1, 53'h100000});
        check("store_hit_line", data_mem[1], {64'h8000_0018_7FFF_FFE7, 64'h8000_0010_7FFF_AABB});

        cfg_stall = 5;
        do_req(64'h8000_0810, 1'b0, '0, '0, rd, lat);
        cfg_stall = 0;
        check("evict_load_data", rd, 64'h8000_0810_7FFF_F7EF);
        check("evict_load_tag", last_tag, {1'b1, 1'b0, 53'h100001});
        check("evict_wb_data", bmem_rd(64'h8000_0010), 64'h8000_0010_7FFF_AABB);
        check("req_stall_len", max_stall, 5);

        do_req(64'h8000_0010, 1'b0, '0, '0, rd, lat);
        check("reload_data", rd, 64'h8000_0010_7FFF_AABB);

        do_req(64'h8000_0010, 1'b1, 64'h0000_0000_1122_0000, 8'h0C, rd, lat);

        // Reset while the first writeback beat is waiting for its ack.
        sv_valid = m_valid; sv_dirty = m_dirty; sv_tag = m_tag;
        cfg_dly = 8;
        model_issue(64'h8000_0810, 1'b0, '0, '0);
        present(64'h8000_0810, 1'b0, '0, '0);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) got = 1'b1;
            n++;
        end
        if (!got) check("abort_wb_timeout", got, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_valid = sv_valid; m_dirty = sv_dirty; m_tag = sv_tag;
        cfg_dly = 0;
        @(negedge clk);
        check("abort_mreq_valid", mem_req_valid, 1'b0);
        check("abort_req_ready", cpu_req_ready, 1'b1);
        stray_req++;
        ev = 0;
        repeat (6) begin
            @(negedge clk);
            if (tag_en || data_en || cpu_resp_valid) ev++;
        end
        check("stray_resp_events", ev, 0);

        do_req(64'h8000_0010, 1'b0, '0, '0, rd, lat);
        check("post_reset_data", rd, 64'h8000_0010_1122_AABB);
        check("post_reset_latency", lat, 2);

        rand_mode = 1'b1;
        tags[0] = 53'h100000; tags[1] = 53'h100001; tags[2] = 53'h100002;
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 4))
                0: idx = 7'd0;
                1: idx = 7'd1;
                2: idx = 7'd2;
                3: idx = 7'd127;
                default: idx = 7'($urandom_range(0, 127));
            endcase
            a = {tags[$urandom_range(0, 2)], idx, 1'($urandom), 3'($urandom)};
            do_req(a, 1'($urandom), {$urandom, $urandom}, 8'($urandom), rd, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        check("left_mem_reqs", q_mem.size(), 0);
        check("left_tag_writes", q_tag.size(), 0);
        check("left_data_writes", q_data.size(), 0);
        check("left_responses", q_resp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Lookup/miss controller for the 128-set direct-mapped data cache.
- Sits between the LSU and the tag/data storage arrays.
- Drives the tag array (7-bit index, 55-bit entry, combinational read, write on en at clock edge) and the 128-bit-line data array.
- Does hit check, write-hit merge, dirty writeback and refill over a 64-bit single-beat memory handshake.

Parameters:
- SETS, 128, number of sets; index width is log2(SETS)=7.
- BEATS, 2, 64-bit memory beats per 16-byte line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req_valid  in  1  LSU request valid
- cpu_req_ready  out  1  controller can accept a request
- cpu_req_addr  in  64  byte address
- cpu_req_wen  in  1  1=store, 0=load
- cpu_req_wdata  in  64  store data
- cpu_req_wmask  in  8  store byte mask
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_rdata  out  64  load data, valid with cpu_resp_valid
- tag_addr  out  7  tag array index
- tag_en  out  1  tag array write enable
- tag_wdata  out  55  {valid, dirty, tag[52:0]}
- tag_rdata  in  55  tag array read data for tag_addr, same cycle
- data_addr  out  7  data array index
- data_en  out  1  data array write enable
- data_wdata  out  128  full line write data
- data_rdata  in  128  data array read line, same cycle
- mem_req_valid  out  1  memory beat request
- mem_req_ready  in  1  memory accepted request
- mem_req_wen  out  1  1=writeback beat, 0=refill beat
- mem_req_addr  out  64  8-byte-aligned beat address
- mem_req_wdata  out  64  writeback beat data
- mem_resp_valid  in  1  beat completion (read data or write ack)
- mem_resp_rdata  in  64  refill beat data

Behaviour:
- Address split: offset = addr[3:0], word select = addr[3], index = addr[10:4], tag = addr[63:11].
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RESP.
- IDLE:
  - cpu_req_ready=1 only here.
  - On cpu_req_valid: latch addr/wen/wdata/wmask, go to LOOKUP.
- LOOKUP:
  - tag_addr = data_addr = latched index.
  - hit = tag_rdata[54] && tag_rdata[52:0] == latched tag.
  - Load hit: latch the addr[3]-selected word of data_rdata, go to RESP.
  - Store hit: same cycle, data_en=1 with data_wdata = data_rdata with the selected word byte-merged by wmask; tag_en=1 with tag_wdata = {1,1,tag}; go to RESP.
  - Miss with valid&&dirty: capture data_rdata and old tag, beat=0, go to WB_REQ.
  - Miss otherwise: beat=0, go to RF_REQ.
- WB_REQ:
  - mem_req_valid=1, wen=1, addr = {old_tag, index, beat, 3'b0}, wdata = captured line word[beat].
  - Hold all request signals stable until mem_req_ready, then go to WB_WAIT.
- WB_WAIT:
  - On mem_resp_valid: if beat==1, beat=0 and go to RF_REQ; else beat=1 and go to WB_REQ.
- RF_REQ:
  - mem_req_valid=1, wen=0, addr = {tag, index, beat, 3'b0}.
  - Hold until mem_req_ready, then go to RF_WAIT.
- RF_WAIT:
  - On mem_resp_valid: store rdata into line buffer word[beat].
  - On beat 1: same cycle data_en=1 with the assembled line and tag_en=1 with {1,0,tag}; go to LOOKUP (replay, guaranteed hit).
- RESP:
  - cpu_resp_valid=1 for exactly one cycle.
  - rdata = latched word for loads, 0 for stores.
  - Go to IDLE.
- Latency:
  - Hit: request accepted at cycle T, resp_valid at T+2, next accept at T+3.
  - Miss: writeback beats (if dirty) + 2 refill beats + replay LOOKUP + RESP.
- Output defaults:
  - tag_en, data_en, mem_req_valid and cpu_resp_valid are 0 outside the states above.
  - tag_addr and data_addr hold the latched index.
- Reset:
  - rst high forces IDLE the next cycle, beat=0, all enables/valids 0, cpu_resp_rdata=0, cpu_req_ready=0 while rst is asserted.
  - Reset mid-transfer abandons the transaction; late mem_resp_valid after reset is ignored.
  - This block never writes the tag array while rst is high.
- mem_resp_valid outside WB_WAIT/RF_WAIT: ignored.
- Back-to-back request: a request presented in the RESP cycle is not accepted until IDLE.
- Index wrap: no special case; index 127 behaves identically to index 0.

Test Plan:
- Cold load at 0x8000_0010 (all invalid) -> two RF beats at 0x8000_0010 and 0x8000_0018; tag[1] written {1,0,0x100000}; resp_valid returns the word for 0x...10.
- Repeat load at 0x8000_0018 -> no mem_req_valid; resp_valid exactly 2 cycles after acceptance with beat-1 data.
- Store 0xAABB at 0x8000_0010, wmask=0x03 -> data_en with only bytes 0-1 changed; tag_wdata dirty=1; resp_valid, no memory traffic.
- Load 0x8000_0810 (same index 1, different tag) -> writeback beats wen=1 at 0x8000_0010/0x8000_0018 with old data incl. 0xAABB, then refill of new line; tag_wdata = {1,0,0x100001}.
- mem_req_ready held low 5 cycles during RF_REQ -> mem_req_valid/addr stable all 5 cycles; cpu_req_ready=0 throughout miss.
- Assert rst during WB_WAIT -> next cycle IDLE, mem_req_valid=0; a subsequent stray mem_resp_valid produces no tag_en/data_en/cpu_resp_valid.
